// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Owns the CGRA program counter and decides, one instruction per cycle, what
// issues next. Scalar instructions step the PC. Taken branches load it from the
// branch immediate. Vector instructions hold the PC while an element loop runs.
// The loop is optionally gated by a stream-out handshake. After the loop the
// sequencer waits DRAIN_CYC cycles so the PE pipeline empties before the next
// issue.
//
// Build option:
//   PC_SEQ_PERF_EN  When defined, perf_retired and perf_stall are live
//                   counters. When undefined, both ports are tied to zero.
//
// Parameters:
//   PC_W       program counter / branch immediate width
//   VLEN_W     vector length and element index width
//   DRAIN_CYC  cycles between the last vector element and the next issue (>= 1)
//
// Ports:
//   axis_aclk         clock
//   axis_resetn       asynchronous active-low reset
//   start             one-cycle pulse; begins execution at start_pc (IDLE only)
//   abort             synchronous; returns to IDLE on the next cycle
//   start_pc, end_pc  program bounds, sampled on start
//   is_not_vect       decoded: current instruction is scalar
//   is_bne, flag_neq  branch-if-not-equal and its datapath flag
//   is_vstreamout     decoded: vector stream-out instruction
//   branch_immediate  absolute branch target
//   vect_len          element count of the current vector instruction
//   so_tready         stream-out sink ready
//   so_tvalid         stream-out beat valid
//   pc                current program counter
//   pc_valid          decode fields for pc are consumed this cycle
//   elem_idx          current vector element index
//   elem_valid        element elem_idx issued this cycle
//   busy              sequencer not in IDLE
//   done              one-cycle pulse at program end
//   perf_retired      retired-instruction count (saturating)
//   perf_stall        STREAM cycles spent waiting on so_tready
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned PC_W      = 12,
    parameter int unsigned VLEN_W    = 16,
    parameter int unsigned DRAIN_CYC = 8
) (
    input  logic              axis_aclk,
    input  logic              axis_resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [PC_W-1:0]   start_pc,
    input  logic [PC_W-1:0]   end_pc,
    input  logic              is_not_vect,
    input  logic              is_bne,
    input  logic              flag_neq,
    input  logic              is_vstreamout,
    input  logic [PC_W-1:0]   branch_immediate,
    input  logic [VLEN_W-1:0] vect_len,
    input  logic              so_tready,
    output logic              so_tvalid,
    output logic [PC_W-1:0]   pc,
    output logic              pc_valid,
    output logic [VLEN_W-1:0] elem_idx,
    output logic              elem_valid,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall
);

    localparam int unsigned DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        VECT,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     end_pc_q;
    logic [VLEN_W-1:0]   vlen_q;
    logic [DCNT_W-1:0]   drain_cnt;

    logic                at_end;
    logic                last_elem;
    logic                drain_last;
    logic                branch_taken;
    logic                zero_len_vect;
    logic                stream_hs;

    // -------------------------------------------------------------------------
    // Condition decode
    // -------------------------------------------------------------------------
    assign at_end        = (pc == end_pc_q);
    // vlen_q is never zero inside a loop, so the subtraction cannot underflow
    // where last_elem is used.
    assign last_elem     = (elem_idx == (vlen_q - VLEN_W'(1)));
    assign drain_last    = (drain_cnt == DCNT_W'(DRAIN_CYC - 1));
    assign branch_taken  = is_bne & flag_neq;
    assign zero_len_vect = ~is_not_vect & (vect_len == '0);
    assign stream_hs     = (state == STREAM) & so_tready;

    // -------------------------------------------------------------------------
    // Outputs are decoded from the state register. elem_valid in STREAM follows
    // so_tready because an element is consumed only on a handshake. so_tvalid
    // depends on state alone, so it cannot drop while the sink stalls.
    // -------------------------------------------------------------------------
    assign pc_valid   = (state == ISSUE);
    assign so_tvalid  = (state == STREAM);
    assign elem_valid = (state == VECT) | stream_hs;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments only. This lets every
    // branch below read the pre-edge values of pc/elem_idx regardless of
    // statement order.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        // NOTE: every register is reset, including end_pc_q/vlen_q/drain_cnt.
        // These are a few flops, not a memory. Resetting them keeps the
        // post-reset state fully defined at negligible cost.
        if (!axis_resetn) begin
            state     <= IDLE;
            pc        <= '0;
            elem_idx  <= '0;
            end_pc_q  <= '0;
            vlen_q    <= '0;
            drain_cnt <= '0;
        end else if (abort) begin
            // pc deliberately holds its value so software can see where the
            // program was stopped.
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pc       <= start_pc;
                        end_pc_q <= end_pc;
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (is_not_vect && branch_taken) begin
                        // A taken branch never ends the program, even at end_pc.
                        pc <= branch_immediate;
                    end else if (is_not_vect || zero_len_vect) begin
                        if (at_end) begin
                            state <= DONE;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end else begin
                        // Capture the length now; decode may change later.
                        vlen_q    <= vect_len;
                        elem_idx  <= '0;
                        drain_cnt <= '0;
                        state     <= is_vstreamout ? STREAM : VECT;
                    end
                end

                VECT: begin
                    if (last_elem) begin
                        state <= DRAIN;
                    end else begin
                        elem_idx <= elem_idx + VLEN_W'(1);
                    end
                end

                STREAM: begin
                    if (so_tready) begin
                        if (last_elem) begin
                            state <= DRAIN;
                        end else begin
                            elem_idx <= elem_idx + VLEN_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (drain_last) begin
                        if (at_end) begin
                            state <= DONE;
                        end else begin
                            pc    <= pc + PC_W'(1);
                            state <= ISSUE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DCNT_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef PC_SEQ_PERF_EN
    logic start_accept;
    logic retire_ev;
    logic stall_ev;

    assign start_accept = (state == IDLE) & start & ~abort;
    // An instruction retires when it leaves ISSUE as a scalar or zero-length
    // vector, including a taken branch. A real vector retires when its drain
    // completes.
    assign retire_ev    = ~abort &
                          (((state == ISSUE) & (is_not_vect | zero_len_vect)) |
                           ((state == DRAIN) & drain_last));
    assign stall_ev     = (state == STREAM) & ~so_tready;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else if (start_accept) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (retire_ev && (perf_retired != '1)) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (stall_ev && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`else
    assign perf_retired = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. A small instruction table indexed by pc
// drives the decode inputs. Each test pushes the PC sequence and element
// indices it expects into scoreboard queues. The per-cycle monitor pops and
// compares them whenever the DUT reports pc_valid or elem_valid. Stream-out
// ready patterns are replayed from a queue on every STREAM cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam int PC_W      = 12;
    localparam int VLEN_W    = 16;
    localparam int DRAIN_CYC = 8;
    localparam logic [31:0] EMPTY = 32'hDEAD_BEEF;

`ifdef PC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              axis_aclk   = 1'b0;
    logic              axis_resetn = 1'b0;
    logic              start       = 1'b0;
    logic              abort       = 1'b0;
    logic [PC_W-1:0]   start_pc    = '0;
    logic [PC_W-1:0]   end_pc      = '0;
    logic              is_not_vect;
    logic              is_bne;
    logic              flag_neq;
    logic              is_vstreamout;
    logic [PC_W-1:0]   branch_immediate;
    logic [VLEN_W-1:0] vect_len;
    logic              so_tready   = 1'b0;
    logic              so_tvalid;
    logic [PC_W-1:0]   pc;
    logic              pc_valid;
    logic [VLEN_W-1:0] elem_idx;
    logic              elem_valid;
    logic              busy;
    logic              done;
    logic [31:0]       perf_retired;
    logic [31:0]       perf_stall;

    typedef struct packed {
        logic              scalar;
        logic              bne;
        logic              flag;
        logic              vstream;
        logic [PC_W-1:0]   imm;
        logic [VLEN_W-1:0] vlen;
    } instr_t;

    instr_t prog [4096];

    assign is_not_vect      = prog[pc].scalar;
    assign is_bne           = prog[pc].bne;
    assign flag_neq         = prog[pc].flag;
    assign is_vstreamout    = prog[pc].vstream;
    assign branch_immediate = prog[pc].imm;
    assign vect_len         = prog[pc].vlen;

    pc_sequencer #(
        .PC_W      (PC_W),
        .VLEN_W    (VLEN_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .axis_aclk        (axis_aclk),
        .axis_resetn      (axis_resetn),
        .start            (start),
        .abort            (abort),
        .start_pc         (start_pc),
        .end_pc           (end_pc),
        .is_not_vect      (is_not_vect),
        .is_bne           (is_bne),
        .flag_neq         (flag_neq),
        .is_vstreamout    (is_vstreamout),
        .branch_immediate (branch_immediate),
        .vect_len         (vect_len),
        .so_tready        (so_tready),
        .so_tvalid        (so_tvalid),
        .pc               (pc),
        .pc_valid         (pc_valid),
        .elem_idx         (elem_idx),
        .elem_valid       (elem_valid),
        .busy             (busy),
        .done             (done),
        .perf_retired     (perf_retired),
        .perf_stall       (perf_stall)
    );

    always #5 axis_aclk = ~axis_aclk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc   [$];
    logic [31:0] exp_elem [$];
    logic        ready_q  [$];
    int          cyc = 0;
    int          last_issue_cyc;
    int          prev_issue_cyc;
    int          done_cyc;
    int          n_tvalid;
    int          n_hs;
    bit          done_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) begin
            prog[i]        = '0;
            prog[i].scalar = 1'b1;
        end
    endtask

    task automatic begin_test();
        exp_pc.delete();
        exp_elem.delete();
        ready_q.delete();
        n_tvalid       = 0;
        n_hs           = 0;
        done_seen      = 1'b0;
        done_cyc       = -1;
        last_issue_cyc = -1;
        prev_issue_cyc = -1;
    endtask

    // One clock: drive per-cycle inputs just after the falling edge, then
    // sample and score the outputs 1 ns later.
    task automatic cycle();
        logic [31:0] e;
        @(negedge axis_aclk);
        if (so_tvalid && ready_q.size() > 0) so_tready = ready_q.pop_front();
        else                                 so_tready = 1'b0;
        #1;
        cyc++;
        if (pc_valid) begin
            e = (exp_pc.size() > 0) ? exp_pc.pop_front() : EMPTY;
            check("pc", 32'(pc), e);
            prev_issue_cyc = last_issue_cyc;
            last_issue_cyc = cyc;
        end
        if (elem_valid) begin
            e = (exp_elem.size() > 0) ? exp_elem.pop_front() : EMPTY;
            check("elem_idx", 32'(elem_idx), e);
        end
        if (so_tvalid)              n_tvalid++;
        if (so_tvalid && so_tready) n_hs++;
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    endtask

    task automatic pulse_start(input logic [PC_W-1:0] sp, input logic [PC_W-1:0] ep);
        start_pc = sp;
        end_pc   = ep;
        start    = 1'b1;
        cycle();
        start    = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_prog(input logic [PC_W-1:0] sp, input logic [PC_W-1:0] ep, input int budget);
        pulse_start(sp, ep);
        for (int i = 0; i < budget && !done_seen; i++) cycle();
        check("done_seen", 32'(done_seen), 32'd1);
        cycle();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("sb_pc_drained", 32'(exp_pc.size()), 32'd0);
        check("sb_elem_drained", 32'(exp_elem.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_elem_idx"}, 32'(elem_idx), 32'd0);
        check({tag, "_pc_valid"}, 32'(pc_valid), 32'd0);
        check({tag, "_elem_valid"}, 32'(elem_valid), 32'd0);
        check({tag, "_so_tvalid"}, 32'(so_tvalid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_perf_retired"}, perf_retired, 32'd0);
        check({tag, "_perf_stall"}, perf_stall, 32'd0);
    endtask

    initial begin
        clear_prog();
        begin_test();

        // Reset state
        repeat (3) @(negedge axis_aclk);
        #1;
        check_reset_outputs("reset");
        axis_resetn = 1'b1;

        // Straight line 0x010..0x013
        begin_test();
        for (int a = 'h10; a <= 'h13; a++) exp_pc.push_back(32'(a));
        run_prog(12'h010, 12'h013, 20);
        check("line_done_latency", 32'(done_cyc - last_issue_cyc), 32'd1);
        check("line_perf_retired", perf_retired, PERF ? 32'd4 : 32'd0);

        // Taken branch at 0x005 -> 0x002
        begin_test();
        prog[12'h005].bne  = 1'b1;
        prog[12'h005].flag = 1'b1;
        prog[12'h005].imm  = 12'h002;
        exp_pc.push_back(32'h005);
        exp_pc.push_back(32'h002);
        exp_pc.push_back(32'h003);
        run_prog(12'h005, 12'h003, 20);

        // Not-taken branch at 0x005 -> 0x006
        begin_test();
        prog[12'h005].flag = 1'b0;
        exp_pc.push_back(32'h005);
        exp_pc.push_back(32'h006);
        run_prog(12'h005, 12'h006, 20);
        check("bne_nt_gap", 32'(last_issue_cyc - prev_issue_cyc), 32'd1);

        // Vector, vect_len=4 at 0x020
        clear_prog();
        begin_test();
        prog[12'h020].scalar = 1'b0;
        prog[12'h020].vlen   = 16'd4;
        exp_pc.push_back(32'h020);
        exp_pc.push_back(32'h021);
        for (int k = 0; k < 4; k++) exp_elem.push_back(32'(k));
        run_prog(12'h020, 12'h021, 40);
        check("vect_issue_gap", 32'(last_issue_cyc - prev_issue_cyc), 32'(4 + DRAIN_CYC + 1));

        // Stream-out, vect_len=3, ready 1,0,0,1,1
        begin_test();
        prog[12'h040].scalar  = 1'b0;
        prog[12'h040].vstream = 1'b1;
        prog[12'h040].vlen    = 16'd3;
        ready_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_pc.push_back(32'h040);
        for (int k = 0; k < 3; k++) exp_elem.push_back(32'(k));
        run_prog(12'h040, 12'h040, 40);
        check("stream_tvalid_cycles", 32'(n_tvalid), 32'd5);
        check("stream_handshakes", 32'(n_hs), 32'd3);
        check("stream_done_latency", 32'(done_cyc - last_issue_cyc), 32'(1 + 5 + DRAIN_CYC));
        check("stream_perf_stall", perf_stall, PERF ? 32'd2 : 32'd0);

        // Zero-length vector is a no-op
        begin_test();
        prog[12'h050].scalar = 1'b0;
        prog[12'h050].vlen   = 16'd0;
        exp_pc.push_back(32'h050);
        exp_pc.push_back(32'h051);
        run_prog(12'h050, 12'h051, 20);
        check("vlen0_gap", 32'(last_issue_cyc - prev_issue_cyc), 32'd1);

        // PC wrap 0xFFF -> 0x000
        begin_test();
        exp_pc.push_back(32'hFFF);
        exp_pc.push_back(32'h000);
        run_prog(12'hFFF, 12'h000, 20);

        // Taken branch at end_pc keeps running; then abort, abort beats start
        begin_test();
        prog[12'h031].bne  = 1'b1;
        prog[12'h031].flag = 1'b1;
        prog[12'h031].imm  = 12'h060;
        exp_pc.push_back(32'h031);
        exp_pc.push_back(32'h060);
        exp_pc.push_back(32'h061);
        exp_pc.push_back(32'h062);
        pulse_start(12'h031, 12'h031);
        repeat (3) cycle();
        check("br_end_no_done", 32'(done_seen), 32'd0);
        check("br_end_sb_pc", 32'(exp_pc.size()), 32'd0);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_issue_busy", 32'(busy), 32'd0);
        check("abort_issue_pc_valid", 32'(pc_valid), 32'd0);
        check("abort_issue_pc_hold", 32'(pc), 32'h062);
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        check("abort_over_start_busy", 32'(busy), 32'd0);

        // Abort mid-STREAM with the sink stalled
        begin_test();
        prog[12'h070].scalar  = 1'b0;
        prog[12'h070].vstream = 1'b1;
        prog[12'h070].vlen    = 16'd3;
        exp_pc.push_back(32'h070);
        pulse_start(12'h070, 12'h070);
        repeat (2) cycle();
        check("stream_stall_tvalid", 32'(so_tvalid), 32'd1);
        check("stream_stall_elem_valid", 32'(elem_valid), 32'd0);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_stream_tvalid", 32'(so_tvalid), 32'd0);
        check("abort_stream_elem_valid", 32'(elem_valid), 32'd0);
        check("abort_stream_busy", 32'(busy), 32'd0);
        check("abort_stream_pc_hold", 32'(pc), 32'h070);

        // Asynchronous reset mid-VECT
        begin_test();
        prog[12'h080].scalar = 1'b0;
        prog[12'h080].vlen   = 16'd10;
        exp_pc.push_back(32'h080);
        for (int k = 0; k < 3; k++) exp_elem.push_back(32'(k));
        pulse_start(12'h080, 12'h081);
        repeat (3) cycle();
        check("vect_mid_elem_valid", 32'(elem_valid), 32'd1);
        axis_resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge axis_aclk);
        axis_resetn = 1'b1;
        #1;
        check("post_reset_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the CGRA program counter and sequences instruction issue.
- Handles three instruction classes:
  - Scalar instructions: advance the PC by one.
  - Taken branches (`bne` with flag): load the PC from the branch immediate.
  - Vector instructions: hold the PC while an element loop runs, optionally gated by a stream-out handshake, then wait for the pipeline to drain.
- Sits between the instruction memory/decoder and the PE array.
- Produces the PC, element index and stall qualifiers consumed by the datapath.

Parameters:
- PC_W, 12, program counter / branch immediate width.
- VLEN_W, 16, vector length and element index width.
- DRAIN_CYC, 8, cycles to wait after the last vector element before the next issue (pipeline depth).

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution at start_pc; ignored while busy.
- abort  in  1  synchronous; returns to IDLE next cycle.
- start_pc  in  PC_W  first instruction address, sampled on start.
- end_pc  in  PC_W  last instruction address, sampled on start.
- is_not_vect  in  1  decoded: current instruction is scalar.
- is_bne  in  1  decoded: current instruction is a branch-if-not-equal.
- flag_neq  in  1  comparison flag from the datapath.
- is_vstreamout  in  1  decoded: vector stream-out instruction.
- branch_immediate  in  PC_W  absolute branch target.
- vect_len  in  VLEN_W  element count of the current vector instruction.
- so_tready  in  1  stream-out sink ready.
- so_tvalid  out  1  stream-out beat valid.
- pc  out  PC_W  current program counter.
- pc_valid  out  1  decode fields for pc are being consumed this cycle.
- elem_idx  out  VLEN_W  current vector element index.
- elem_valid  out  1  element elem_idx issued this cycle.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse at program end.

Behaviour:
- Reset (axis_resetn=0, asynchronous, any state):
  - state=IDLE; pc=0; elem_idx=0.
  - pc_valid, elem_valid, so_tvalid, busy and done are all 0.
- Decode inputs are combinational functions of pc; they are valid whenever pc_valid=1.
- States: IDLE, ISSUE, VECT, STREAM, DRAIN, DONE.
- IDLE:
  - On start: pc<=start_pc, latch end_pc, then go to ISSUE.
  - busy=1 from the next cycle.
- ISSUE (pc_valid=1), one decision per cycle:
  - Scalar, not (is_bne & flag_neq): pc<=pc+1.
  - Scalar, is_bne & flag_neq: pc<=branch_immediate.
  - Vector, vect_len=0: treated as a no-op; pc<=pc+1.
  - Vector, not stream-out, vect_len>0: elem_idx<=0, go to VECT.
  - Vector, is_vstreamout, vect_len>0: elem_idx<=0, go to STREAM.
  - Retire at end: if a scalar (or zero-length vector) retires with pc==end_pc, go to DONE instead of updating pc. A taken branch at end_pc branches and does not end.
- VECT:
  - elem_valid=1 every cycle; elem_idx increments.
  - At elem_idx==vect_len-1: go to DRAIN.
- STREAM:
  - so_tvalid=1 and elem_valid=so_tready.
  - elem_idx advances only on so_tvalid&so_tready.
  - so_tvalid stays asserted while so_tready=0 (AXI-S rule; no withdrawal).
  - On the last handshake: go to DRAIN.
- DRAIN:
  - Counts DRAIN_CYC cycles; pc_valid=0, elem_valid=0.
  - Then either go to DONE (if pc==end_pc) or set pc<=pc+1 and go to ISSUE.
- DONE: done=1 for one cycle; go to IDLE; busy drops the next cycle.
- PC arithmetic: modulo 2^PC_W; pc+1 wraps from all-ones to 0.
- vect_len is sampled on entry to VECT/STREAM. A change mid-loop is ignored.
- abort in any state: go to IDLE next cycle, with so_tvalid, elem_valid and pc_valid cleared. pc holds its value. Abort overrides start.
- Latency: scalar issue is 1 instruction per cycle. A vector instruction takes vect_len + DRAIN_CYC + 1 cycles (plus stall cycles in STREAM).

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined:
  - Adds output perf_retired (32 bits) counting retired instructions; saturates at all-ones.
  - Adds output perf_stall (32 bits) counting STREAM cycles with so_tready=0.
  - Both counters clear on reset and on start.
- Undefined: both ports exist and are tied to 0; no counter logic.

Test Plan:
- Straight line: start_pc=0x010, end_pc=0x013, all scalar. Expect pc 0x010..0x013 on consecutive cycles, done pulse 1 cycle after 0x013, busy low after that.
- Branch: bne at 0x005, flag_neq=1, imm=0x002. Expect next pc=0x002. Repeat with flag_neq=0: expect next pc=0x006.
- Vector: vect_len=4, DRAIN_CYC=8 at pc 0x020. Expect elem_idx 0..3 with elem_valid=1, then 8 idle cycles, then pc=0x021.
- Streamout: vect_len=3, so_tready toggling 1,0,0,1,1. Expect so_tvalid held high through stalls, exactly 3 handshakes, then drain. With PC_SEQ_PERF_EN: perf_stall=2.
- Edge cases:
  - vect_len=0: pc+1 next cycle, no elem_valid.
  - pc=0xFFF scalar with end_pc=0x000: pc wraps to 0x000, then done.
- Interrupts: abort mid-STREAM and axis_resetn low mid-VECT. Expect so_tvalid=0 next cycle after abort and immediately on reset; reset outputs exactly as listed under Behaviour.
